// File: rtl/fetch_pkg.sv
// Shared constants and slot layout for the instruction-fetch front end.
package fetch_pkg;

   localparam int unsigned INSTR_BYTES           = 4;
   localparam logic [31:0] DEFAULT_START_ADDRESS = 32'h0000_0000;
   localparam int unsigned SLOT_XLEN             = 32;
   localparam int unsigned SLOT_ADDR_WIDTH       = 32;

   typedef struct packed {
      logic [SLOT_ADDR_WIDTH-1:0] pc;
      logic [SLOT_XLEN-1:0]       data;
      logic                       filled;
   } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_buffer.sv
// Ring of fetch slots: allocated in request order, filled in response order,
// drained at the head. Pointers carry one wrap bit so full and empty differ.
module fetch_slot_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN       = SLOT_XLEN,
   parameter int unsigned ADDR_WIDTH = SLOT_ADDR_WIDTH,
   parameter int unsigned DEPTH      = 4,
   localparam int unsigned PW        = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  alloc_i,
   input  logic [ADDR_WIDTH-1:0] alloc_pc_i,
   input  logic                  fill_i,
   input  logic [XLEN-1:0]       fill_data_i,
   input  logic                  consume_i,
   output logic [PW:0]           count_o,
   output logic [PW:0]           unfilled_o,
   output logic                  head_valid_o,
   output logic [ADDR_WIDTH-1:0] head_pc_o,
   output logic [XLEN-1:0]       head_data_o
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [XLEN-1:0]       data;
      logic                  filled;
   } slot_t;

   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

   slot_t [DEPTH-1:0] slot_q;
   logic  [PW:0]      head_q, alloc_q, fill_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q  <= '0;
         head_q  <= '0;
         alloc_q <= '0;
         fill_q  <= '0;
      end else if (flush_i) begin
         head_q  <= '0;
         alloc_q <= '0;
         fill_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_q[PW'(i)].filled <= 1'b0;
         end
      end else begin
         // Alloc targets a free slot and fill an allocated one, so they never collide.
         if (alloc_i) begin
            slot_q[alloc_q[PW-1:0]].pc     <= alloc_pc_i;
            slot_q[alloc_q[PW-1:0]].filled <= 1'b0;
            alloc_q                        <= alloc_q + PTR_ONE;
         end
         if (fill_i) begin
            slot_q[fill_q[PW-1:0]].data   <= fill_data_i;
            slot_q[fill_q[PW-1:0]].filled <= 1'b1;
            fill_q                        <= fill_q + PTR_ONE;
         end
         if (consume_i) begin
            head_q <= head_q + PTR_ONE;
         end
      end
   end

   assign count_o      = alloc_q - head_q;
   assign unfilled_o   = alloc_q - fill_q;
   // A drained ring can leave a stale filled bit at the head; count masks it.
   assign head_valid_o = slot_q[head_q[PW-1:0]].filled && (count_o != '0);
   assign head_pc_o    = slot_q[head_q[PW-1:0]].pc;
   assign head_data_o  = slot_q[head_q[PW-1:0]].data;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited memory
// requests, stale-response dropping after redirects, buffered decoder delivery.
module prefetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned           XLEN          = 32,
   parameter int unsigned           ADDR_WIDTH    = 32,
   parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = ADDR_WIDTH'(DEFAULT_START_ADDRESS),
   parameter int unsigned           FIFO_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [XLEN-1:0]       imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [XLEN-1:0]       instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW:0]           drop_q, drop_d;
   logic [PW:0]           count, unfilled;
   logic [PW+1:0]         inflight, drop_sum;
   logic                  req_hs, consume, fill;

   // Credit covers both live slots and responses still owed for flushed ones.
   assign inflight       = {1'b0, count} + {1'b0, drop_q};
   assign imem_req_valid = rst_n && (inflight < (PW+2)'(FIFO_DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign consume        = instr_valid && instr_ready;
   assign fill           = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
   assign drop_sum       = {1'b0, drop_q} + {1'b0, unfilled}
                         + (PW+2)'(req_hs) - (PW+2)'(imem_rsp_valid);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
         drop_d     = drop_sum[PW:0];
      end else begin
         if (req_hs) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INSTR_BYTES);
         end
         if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - (PW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= START_ADDRESS;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

   fetch_slot_buffer #(
      .XLEN       (XLEN),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_slots (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .flush_i      (redirect_valid),
      .alloc_i      (req_hs),
      .alloc_pc_i   (fetch_pc_q),
      .fill_i       (fill),
      .fill_data_i  (imem_rsp_data),
      .consume_i    (consume),
      .count_o      (count),
      .unfilled_o   (unfilled),
      .head_valid_o (instr_valid),
      .head_pc_o    (instr_pc),
      .head_data_o  (instr_data)
   );

   a_rsp_owed: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> ((count != '0) || (drop_q != '0)));

endmodule

// File: tb/tb_prefetch_unit.sv
// Scoreboard bench for prefetch_unit with an in-order, fixed-latency memory model.
module tb_prefetch_unit;

   localparam logic [31:0] START = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        instr_valid, instr_ready;
   logic [31:0] instr_data, instr_pc;

   prefetch_unit #(
      .XLEN(32), .ADDR_WIDTH(32), .START_ADDRESS(START), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

   mreq_t       mq[$];
   exp_t        sb[$];
   int          n_checks = 0, n_fail = 0, cyc = 0, lat = 1;
   bit          req_rdy, dec_rdy, redir;
   logic [31:0] redir_addr, exp_addr;
   bit          o_req_valid, o_instr_valid, o_hs, o_cs, o_rs;
   bit          pre_req_valid, pre_instr_valid;
   logic [31:0] o_addr, o_pc;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // One clock cycle: drive at negedge, sample, then update models after posedge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      o_rs           = (mq.size() > 0) && (mq[0].due <= cyc);
      imem_rsp_valid = o_rs;
      imem_rsp_data  = o_rs ? mem_data(mq[0].addr) : 32'h0;
      imem_req_ready = req_rdy;
      instr_ready    = dec_rdy;
      redirect_valid = redir;
      redirect_addr  = redir_addr;
      #1;
      o_req_valid   = imem_req_valid;
      o_instr_valid = instr_valid;
      o_hs          = imem_req_valid && imem_req_ready;
      o_cs          = instr_valid && instr_ready;
      o_addr        = imem_req_addr;
      o_pc          = instr_pc;
      if (o_hs) begin
         n_checks++;
         if (imem_req_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, imem_req_addr, exp_addr);
         end
      end
      if (o_cs) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL deliver_extra cyc=%0d got pc=%h want none", cyc, instr_pc);
         end else begin
            e = sb.pop_front();
            if (instr_pc !== e.pc || instr_data !== e.data) begin
               n_fail++;
               $display("FAIL deliver cyc=%0d got pc=%h data=%h want pc=%h data=%h",
                        cyc, instr_pc, instr_data, e.pc, e.data);
            end
         end
      end
      @(posedge clk);
      if (o_rs) void'(mq.pop_front());
      if (o_hs) mq.push_back('{addr: o_addr, due: cyc + lat});
      if (redir) begin
         sb.delete();
         exp_addr = {redir_addr[31:2], 2'b00};
      end else if (o_hs) begin
         sb.push_back('{pc: o_addr, data: mem_data(o_addr)});
         exp_addr = o_addr + 32'd4;
      end
      redir = 1'b0;
      cyc++;
   endtask

   task automatic reset_assert();
      @(negedge clk);
      pre_req_valid   = imem_req_valid;
      pre_instr_valid = instr_valid;
      rst_n = 1'b0;
      req_rdy = 0; dec_rdy = 0; redir = 0; redir_addr = 0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
      instr_ready = 0; redirect_valid = 0; redirect_addr = 0;
      mq.delete(); sb.delete();
      exp_addr = START;
      #1;
   endtask

   task automatic reset_release();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic test_reset();
      reset_assert();
      n_checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valids got req=%b instr=%b want 0 0", imem_req_valid, instr_valid);
      end
      n_checks++;
      if (instr_pc !== 32'h0 || instr_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got pc=%h data=%h want 0 0", instr_pc, instr_data);
      end
      reset_release();
      req_rdy = 1; lat = 1;
      cycle();
      n_checks++;
      if (!o_req_valid || o_addr !== START) begin
         n_fail++;
         $display("FAIL reset_first_req got v=%b addr=%h want 1 %h", o_req_valid, o_addr, START);
      end
   endtask

   task automatic test_stream();
      int first_v = -1, deliv = 0, c;
      reset_assert(); reset_release();
      lat = 1; req_rdy = 1; dec_rdy = 1;
      for (int i = 0; i < 20; i++) begin
         c = cyc;
         cycle();
         if (o_instr_valid && first_v < 0) first_v = c;
         if (o_cs) deliv++;
      end
      // Request in cycle 0, response in cycle 1, decoder sees it in cycle 2.
      n_checks++;
      if (first_v != 2) begin
         n_fail++;
         $display("FAIL stream_latency got=%0d want=2", first_v);
      end
      n_checks++;
      if (deliv != 18) begin
         n_fail++;
         $display("FAIL stream_throughput got=%0d want=18", deliv);
      end
   endtask

   task automatic test_stall();
      int nreq = 0, deliv = 0;
      bit full_seen = 0;
      reset_assert(); reset_release();
      lat = 1; req_rdy = 1; dec_rdy = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (full_seen) begin
            n_checks++;
            if (o_req_valid) begin
               n_fail++;
               $display("FAIL stall_req_low cyc=%0d got=1 want=0", cyc - 1);
            end
         end
         if (o_hs) nreq++;
         if (nreq == 4) full_seen = 1;
      end
      n_checks++;
      if (nreq != 4) begin
         n_fail++;
         $display("FAIL stall_req_count got=%0d want=4", nreq);
      end
      n_checks++;
      if (!o_instr_valid || o_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL stall_head got v=%b pc=%h want 1 0", o_instr_valid, o_pc);
      end
      dec_rdy = 1;
      for (int i = 0; i < 40 && deliv < 10; i++) begin
         cycle();
         if (o_cs) deliv++;
      end
      n_checks++;
      if (deliv != 10) begin
         n_fail++;
         $display("FAIL stall_drain got=%0d want=10", deliv);
      end
   endtask

   task automatic test_redirect_drop();
      bit got = 0;
      reset_assert(); reset_release();
      lat = 3; req_rdy = 1; dec_rdy = 1;
      cycle(); cycle();
      redir = 1; redir_addr = 32'h100;
      cycle();
      for (int i = 0; i < 20 && !got; i++) begin
         cycle();
         got = o_cs;
      end
      n_checks++;
      if (!got || o_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL redir_first got v=%b pc=%h want 1 100", got, o_pc);
      end
      n_checks++;
      if (dut.drop_q !== '0) begin
         n_fail++;
         $display("FAIL redir_drop_clear got=%0d want=0", dut.drop_q);
      end
   endtask

   task automatic test_redirect_coincident();
      int c = 0;
      bit got = 0;
      reset_assert(); reset_release();
      lat = 1; req_rdy = 1; dec_rdy = 1;
      repeat (5) cycle();
      redir = 1; redir_addr = 32'h200;
      cycle();
      n_checks++;
      if (!(o_hs && o_rs && o_cs)) begin
         n_fail++;
         $display("FAIL coinc_events got hs=%b rsp=%b cons=%b want 1 1 1", o_hs, o_rs, o_cs);
      end
      cycle();
      n_checks++;
      if (!o_hs || o_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL coinc_next_req got v=%b addr=%h want 1 200", o_hs, o_addr);
      end
      for (int i = 0; i < 20 && !got; i++) begin
         c = cyc;
         cycle();
         got = o_cs;
      end
      // Redirect in cycle 5 gives earliest delivery in cycle 8.
      n_checks++;
      if (!got || c != 8 || o_pc !== 32'h200) begin
         n_fail++;
         $display("FAIL coinc_deliver got v=%b cyc=%0d pc=%h want 1 8 200", got, c, o_pc);
      end
   endtask

   task automatic test_align_wrap();
      logic [31:0] d[$];
      reset_assert(); reset_release();
      lat = 1; req_rdy = 1; dec_rdy = 1;
      repeat (3) cycle();
      redir = 1; redir_addr = 32'h103;
      cycle(); cycle();
      n_checks++;
      if (!o_hs || o_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL align_req got v=%b addr=%h want 1 100", o_hs, o_addr);
      end
      redir = 1; redir_addr = 32'hFFFF_FFFC;
      cycle(); cycle();
      if (o_cs) d.push_back(o_pc);
      n_checks++;
      if (!o_hs || o_addr !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL wrap_req0 got v=%b addr=%h want 1 fffffffc", o_hs, o_addr);
      end
      cycle();
      if (o_cs) d.push_back(o_pc);
      n_checks++;
      if (!o_hs || o_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_req1 got v=%b addr=%h want 1 0", o_hs, o_addr);
      end
      for (int i = 0; i < 20 && d.size() < 2; i++) begin
         cycle();
         if (o_cs) d.push_back(o_pc);
      end
      n_checks++;
      if (d.size() < 2 || d[0] !== 32'hFFFF_FFFC || d[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_deliver got n=%0d want pcs fffffffc then 0", d.size());
      end
   endtask

   task automatic test_reset_mid();
      bit got = 0;
      reset_assert(); reset_release();
      lat = 3; req_rdy = 1; dec_rdy = 0;
      repeat (3) cycle();
      req_rdy = 0;
      cycle();
      reset_assert();
      n_checks++;
      if (pre_req_valid !== 1'b1 || pre_instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre got req=%b instr=%b want 1 1", pre_req_valid, pre_instr_valid);
      end
      n_checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset got req=%b instr=%b want 0 0", imem_req_valid, instr_valid);
      end
      reset_release();
      lat = 1; req_rdy = 1; dec_rdy = 1;
      cycle();
      n_checks++;
      if (!o_hs || o_addr !== START) begin
         n_fail++;
         $display("FAIL mid_restart got v=%b addr=%h want 1 %h", o_hs, o_addr, START);
      end
      for (int i = 0; i < 10 && !got; i++) begin
         cycle();
         got = o_cs;
      end
      n_checks++;
      if (!got || o_pc !== START) begin
         n_fail++;
         $display("FAIL mid_deliver got v=%b pc=%h want 1 %h", got, o_pc, START);
      end
   endtask

   initial begin
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
      redirect_valid = 0; redirect_addr = 0; instr_ready = 0;
      redir_addr = 0; exp_addr = START;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drop();
      test_redirect_coincident();
      test_align_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
